// File: rtl/onchip_mem_mover.sv
// FILL/COPY mover over an Avalon-MM on-chip RAM; FILL takes N+2 cycles start-to-done, COPY 3N+2, error 2.
// No backpressure: the memory has a fixed 1-cycle read latency and no waitrequest.
module onchip_mem_mover #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  op,
  input  logic [ADDR_W-1:0]     src_addr,
  input  logic [ADDR_W-1:0]     dst_addr,
  input  logic [ADDR_W:0]       length,
  input  logic [DATA_W-1:0]     fill_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_W-1:0]     address,
  output logic [DATA_W/8-1:0]   byteenable,
  output logic                  chipselect,
  output logic                  write,
  output logic [DATA_W-1:0]     writedata,
  output logic                  clken,
  input  logic [DATA_W-1:0]     readdata
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_FILL_WR = 3'd2,
    S_CP_RD   = 3'd3,
    S_CP_CAP  = 3'd4,
    S_CP_WR   = 3'd5,
    S_FINISH  = 3'd6
  } state_t;

  localparam logic [ADDR_W+1:0] LP_LIMIT = {2'b01, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] LP_A_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   LP_L_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t              r_state;
  logic                r_op;
  logic [ADDR_W-1:0]   r_src;
  logic [ADDR_W-1:0]   r_dst;
  logic [ADDR_W:0]     r_len;
  logic [DATA_W-1:0]   r_fill;
  logic                r_busy;
  logic                r_done;
  logic                r_error;
  logic [ADDR_W-1:0]   r_address;
  logic                r_cs;
  logic                r_write;
  logic [DATA_W-1:0]   r_wdata;

  logic [ADDR_W+1:0]   w_dst_end;
  logic [ADDR_W+1:0]   w_src_end;
  logic                w_cmd_err;
  logic                w_last;

  // Range ends are computed two bits wider so a full-memory transfer cannot alias to zero.
  assign w_dst_end = {2'b00, r_dst} + {1'b0, r_len};
  assign w_src_end = {2'b00, r_src} + {1'b0, r_len};
  assign w_cmd_err = (r_len == '0) || (w_dst_end > LP_LIMIT) ||
                     (r_op && (w_src_end > LP_LIMIT));
  assign w_last    = (r_len == LP_L_ONE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_op      <= 1'b0;
      r_src     <= '0;
      r_dst     <= '0;
      r_len     <= '0;
      r_fill    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_address <= '0;
      r_cs      <= 1'b0;
      r_write   <= 1'b0;
      r_wdata   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_src   <= src_addr;
            r_dst   <= dst_addr;
            r_len   <= length;
            r_fill  <= fill_data;
            r_busy  <= 1'b1;
            r_error <= 1'b0;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_cmd_err) begin
            r_error <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_FINISH;
          end else if (!r_op) begin
            r_cs      <= 1'b1;
            r_write   <= 1'b1;
            r_address <= r_dst;
            r_wdata   <= r_fill;
            r_state   <= S_FILL_WR;
          end else begin
            r_cs      <= 1'b1;
            r_write   <= 1'b0;
            r_address <= r_src;
            r_state   <= S_CP_RD;
          end
        end
        S_FILL_WR: begin
          r_dst <= r_dst + LP_A_ONE;
          r_len <= r_len - LP_L_ONE;
          if (w_last) begin
            r_cs    <= 1'b0;
            r_write <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_FINISH;
          end else begin
            r_address <= r_dst + LP_A_ONE;
          end
        end
        S_CP_RD: begin
          r_cs    <= 1'b0;
          r_state <= S_CP_CAP;
        end
        S_CP_CAP: begin
          // Read data returns exactly one cycle after the read strobe.
          r_wdata   <= readdata;
          r_cs      <= 1'b1;
          r_write   <= 1'b1;
          r_address <= r_dst;
          r_state   <= S_CP_WR;
        end
        S_CP_WR: begin
          r_src <= r_src + LP_A_ONE;
          r_dst <= r_dst + LP_A_ONE;
          r_len <= r_len - LP_L_ONE;
          if (w_last) begin
            r_cs    <= 1'b0;
            r_write <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_FINISH;
          end else begin
            r_cs      <= 1'b1;
            r_write   <= 1'b0;
            r_address <= r_src + LP_A_ONE;
            r_state   <= S_CP_RD;
          end
        end
        S_FINISH: begin
          r_busy  <= 1'b0;
          r_error <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_cs    <= 1'b0;
          r_write <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;
  assign address    = r_address;
  assign chipselect = r_cs;
  assign write      = r_write;
  assign writedata  = r_wdata;
  assign byteenable = '1;
  assign clken      = 1'b1;

endmodule

// File: tb/tb_onchip_mem_mover.sv
// Bench for onchip_mem_mover: 1-cycle-latency RAM slave plus an array-level reference of FILL/COPY results.
module tb_onchip_mem_mover;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [12:0] src_addr = '0;
  logic [12:0] dst_addr = '0;
  logic [13:0] length = '0;
  logic [31:0] fill_data = '0;
  logic        busy, done, error;
  logic [12:0] address;
  logic [3:0]  byteenable;
  logic        chipselect, write, clken;
  logic [31:0] writedata;
  logic [31:0] readdata;

  onchip_mem_mover #(.ADDR_W(13), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length), .fill_data(fill_data),
    .busy(busy), .done(done), .error(error),
    .address(address), .byteenable(byteenable), .chipselect(chipselect), .write(write),
    .writedata(writedata), .clken(clken), .readdata(readdata)
  );

  initial forever #5 clk = ~clk;

  // RAM slave with a preload port used only while the mover is idle.
  logic [31:0] mem [8192];
  logic [31:0] ref_mem [8192];
  logic [31:0] rd_q = '0;
  logic        pl_en = 1'b0;
  logic [12:0] pl_addr = '0;
  logic [31:0] pl_dat = '0;
  assign readdata = rd_q;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_dat;
    else begin
      if (chipselect && write) mem[address] <= writedata;
      if (chipselect && !write) rd_q <= mem[address];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int cs_cnt = 0, viol = 0, done_cnt = 0, done_cyc = 0;
  logic done_err = 1'b0, done_busy = 1'b0;
  int wr_addr_q[$];
  int wr_cyc_q[$];

  always @(negedge clk) begin
    if (chipselect) cs_cnt++;
    if (write && !chipselect) viol++;
    if (chipselect && write) begin
      wr_addr_q.push_back(int'(address));
      wr_cyc_q.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc  = cyc;
      done_err  = error;
      done_busy = busy;
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic preload(input int a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a[12:0]; pl_dat = d;
    ref_mem[a] = d;
    tick;
    pl_en = 1'b0;
  endtask

  task automatic cmp_mem(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 8192; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk({tag, ".mem"}, bad, 0);
  endtask

  task automatic run_op(input string tag, input bit op_i, input int src_i, input int dst_i,
                        input int len_i, input logic [31:0] fd, input bit spur);
    int c0, d0, k0, cs0, exp_lat, gap, bad, nwr;
    bit exp_err;
    exp_err = (len_i == 0) || (dst_i + len_i > 8192) || (op_i && (src_i + len_i > 8192));
    if (!exp_err) begin
      for (int i = 0; i < len_i; i++) ref_mem[dst_i + i] = op_i ? ref_mem[src_i + i] : fd;
    end
    exp_lat = exp_err ? 2 : (op_i ? 3 * len_i + 2 : len_i + 2);
    d0 = done_cnt; k0 = wr_addr_q.size(); cs0 = cs_cnt; c0 = cyc;
    start = 1'b1; op = op_i; src_addr = src_i[12:0]; dst_addr = dst_i[12:0];
    length = len_i[13:0]; fill_data = fd;
    tick;
    start = 1'b0; op = ~op_i;
    src_addr = 13'($urandom); dst_addr = 13'($urandom); length = 14'($urandom); fill_data = $urandom;
    for (int i = 0; i < 40000 && done_cnt == d0; i++) begin
      start = spur && (i == 3);
      tick;
    end
    start = 1'b0;
    chk({tag, ".done_cnt"}, done_cnt - d0, 1);
    chk({tag, ".latency"}, done_cyc - c0, exp_lat);
    chk({tag, ".error"}, done_err, exp_err);
    chk({tag, ".busy_at_done"}, done_busy, 1'b1);
    tick;
    chk({tag, ".busy_after"}, busy, 1'b0);
    chk({tag, ".done_after"}, done, 1'b0);
    if (exp_err) chk({tag, ".no_bus"}, cs_cnt - cs0, 0);
    else begin
      nwr = wr_addr_q.size() - k0;
      chk({tag, ".nwrites"}, nwr, len_i);
      chk({tag, ".first_wr_cyc"}, wr_cyc_q[k0] - c0, op_i ? 4 : 2);
      gap = op_i ? 3 : 1;
      bad = 0;
      for (int i = 0; i < nwr; i++) begin
        if (wr_addr_q[k0 + i] != dst_i + i) bad++;
        if (i > 0 && wr_cyc_q[k0 + i] != wr_cyc_q[k0 + i - 1] + gap) bad++;
      end
      chk({tag, ".wr_sequence"}, bad, 0);
    end
    cmp_mem(tag);
  endtask

  int  r_len, r_src, r_dst, c0, cs0, d0;
  bit  r_op;

  initial begin
    // Reset values.
    repeat (3) tick;
    chk("rst.busy", busy, 1'b0);
    chk("rst.done", done, 1'b0);
    chk("rst.error", error, 1'b0);
    chk("rst.cs", chipselect, 1'b0);
    chk("rst.write", write, 1'b0);
    chk("rst.address", address, 13'h0);
    chk("rst.writedata", writedata, 32'h0);
    chk("rst.clken", clken, 1'b1);
    chk("rst.byteenable", byteenable, 4'hF);
    reset_n = 1'b1;
    tick;

    for (int i = 0; i < 8192; i++) preload(i, $urandom);
    for (int i = 0; i < 8; i++) preload(i, i);

    run_op("fill_0x100", 1'b0, 0, 'h100, 4, 32'hA5A5A5A5, 1'b0);
    chk("fill_0x100.word3", mem['h103], 32'hA5A5A5A5);
    run_op("copy_8", 1'b1, 'h000, 'h010, 8, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) chk("copy_8.word", mem['h010 + i], i);
    run_op("copy_len0", 1'b1, 'h20, 'h40, 0, 32'h0, 1'b0);
    run_op("fill_over_end", 1'b0, 0, 'h1FFF, 2, 32'h12345678, 1'b0);
    run_op("copy_src_over_end", 1'b1, 'h1FF0, 'h0100, 'h20, 32'h0, 1'b0);
    run_op("fill_last_word", 1'b0, 0, 'h1FFF, 1, 32'hCAFEF00D, 1'b0);
    run_op("copy_overlap", 1'b1, 'h300, 'h302, 12, 32'h0, 1'b0);
    run_op("fill_spur_start", 1'b0, 0, 'h500, 20, 32'h5A5A0F0F, 1'b1);
    run_op("copy_spur_start", 1'b1, 'h600, 'h700, 6, 32'h0, 1'b1);

    for (int t = 0; t < 8; t++) begin
      r_op  = 1'($urandom_range(0, 1));
      r_len = $urandom_range(1, 48);
      r_src = $urandom_range(0, 8192 - r_len);
      r_dst = $urandom_range(0, 8192 - r_len);
      if (t == 3) begin
        r_op = 1'b1; r_len = $urandom_range(8, 40);
        r_src = $urandom_range(0, 4000); r_dst = r_src + $urandom_range(1, 5);
      end
      if (t == 6) begin
        r_dst = $urandom_range(8000, 8191);
        r_len = 8192 - r_dst + $urandom_range(1, 5);
      end
      run_op("random", r_op, r_src, r_dst, r_len, $urandom, 1'b0);
    end

    // Reset during word 3 of a 10-word copy.
    for (int i = 0; i < 2; i++) ref_mem['h900 + i] = ref_mem['h800 + i];
    c0 = cyc; d0 = done_cnt;
    start = 1'b1; op = 1'b1; src_addr = 13'h800; dst_addr = 13'h900; length = 14'd10;
    tick;
    start = 1'b0;
    for (int i = 0; i < 20 && cyc < c0 + 8; i++) tick;
    reset_n = 1'b0;
    tick;
    chk("midrst.busy", busy, 1'b0);
    chk("midrst.cs", chipselect, 1'b0);
    chk("midrst.write", write, 1'b0);
    chk("midrst.address", address, 13'h0);
    cs0 = cs_cnt;
    tick;
    reset_n = 1'b1;
    repeat (6) tick;
    chk("midrst.no_bus_after", cs_cnt - cs0, 0);
    chk("midrst.no_done", done_cnt - d0, 0);
    cmp_mem("midrst");
    run_op("fill_after_rst", 1'b0, 0, 'hA00, 5, 32'h0BADBEEF, 1'b0);

    run_op("fill_full", 1'b0, 0, 0, 8192, 32'h13579BDF, 1'b0);
    chk("fill_full.last_addr", wr_addr_q[wr_addr_q.size() - 1], 'h1FFF);

    chk("protocol.write_without_cs", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
